// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and DTIM word-port bundle for the load/store unit
interface lsu_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_cause;
  logic              dtim_o_en;
  logic [ADDR_W-1:0] dtim_o_addr;
  logic [3:0]        dtim_o_wmask;
  logic [31:0]       dtim_o_wdata;
  logic [31:0]       dtim_i_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dtim_i_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_cause,
           dtim_o_en, dtim_o_addr, dtim_o_wmask, dtim_o_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dtim_i_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_cause,
           dtim_o_en, dtim_o_addr, dtim_o_wmask, dtim_o_wdata
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit driving the DTIM word port, one request outstanding
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses respond with cause 01 instead of being realigned.
module lsu #(
  parameter int          ADDR_W    = 12,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cause_q;
  logic [31:0]       rdata_q;
  logic [1:0]        wait_cnt;

  logic              illegal;
  logic              out_of_range;
  logic [1:0]        chk_cause;
  logic [ADDR_W-1:0] eff_addr;
  logic [3:0]        store_mask;
  logic [31:0]       store_data;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  // Request check; funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    illegal      = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3 == 3'b011)
                              : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
    out_of_range = bus.req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W];
    eff_addr     = bus.req_addr[ADDR_W-1:0];
    case (bus.req_funct3[1:0])
      2'b01:   eff_addr[0]   = 1'b0;
      2'b10:   eff_addr[1:0] = 2'b00;
      default: ;
    endcase
    chk_cause = 2'b00;
    if (illegal)
      chk_cause = 2'b11;
    else if (out_of_range)
      chk_cause = 2'b10;
`ifdef LSU_MISALIGN_TRAP_EN
    else if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
             (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00))
      chk_cause = 2'b01;
`else
    else
      chk_cause = 2'b00;
`endif
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        store_mask = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_mask = 4'b0011 << addr_q[1:0];
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted = bus.dtim_i_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // DTIM outputs decode from state so an async reset drops wmask in the same instant.
  always_comb begin
    state_nx         = state;
    bus.req_ready    = (state == IDLE);
    bus.rsp_valid    = (state == RESP);
    bus.dtim_o_en    = 1'b0;
    bus.dtim_o_addr  = '0;
    bus.dtim_o_wmask = 4'b0000;
    bus.dtim_o_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (bus.req_valid)
          state_nx = (chk_cause != 2'b00) ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.dtim_o_en   = 1'b1;
        bus.dtim_o_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (we_q) begin
          bus.dtim_o_wmask = store_mask;
          bus.dtim_o_wdata = store_data;
          state_nx         = RESP;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == LAST_WAIT)
          state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      cause_q  <= 2'b00;
      rdata_q  <= 32'd0;
      wait_cnt <= 2'd0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= eff_addr;
        wdata_q <= bus.req_wdata;
        cause_q <= chk_cause;
        rdata_q <= 32'd0;
      end
      if (state == ACCESS)
        wait_cnt <= 2'd0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
        if (wait_cnt == LAST_WAIT)
          rdata_q <= load_val;
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_cause = cause_q;

endmodule
